// File: rtl/vending_machine_ctrl.sv
// vending_machine_ctrl
//   Vending-machine controller. Credit builds up from three configurable coin
//   values. The item is dispensed automatically once credit reaches PRICE.
//   Change is paid back as one CHANGE_UNIT per cycle. cancel refunds the
//   whole credit.
//
// Ports
//   CLK          clock; all state changes on the rising edge
//   RST          synchronous, active-high reset
//   coin_valid   a coin is presented this cycle
//   coin_sel     coin type 0/1/2 -> COIN0/1/2; 3 is an invalid coin
//   cancel       refund request (honoured only when idle with credit > 0)
//   dispense     one-cycle vend pulse (high while in VEND)
//   change_out   one CHANGE_UNIT returned this cycle (high while in CHANGE)
//   coin_reject  one-cycle pulse: the previous cycle's coin was rejected
//   busy         high in VEND or CHANGE
//   credit       current credit
//   vend_count   total vends, wraps modulo 2**CNT_W
module vending_machine_ctrl #(
  parameter int CREDIT_W    = 8,
  parameter int CNT_W       = 8,
  parameter int PRICE       = 25,
  parameter int COIN0       = 5,
  parameter int COIN1       = 10,
  parameter int COIN2       = 25,
  parameter int CHANGE_UNIT = 5,
  parameter int MAX_CREDIT  = 2**CREDIT_W-1
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                coin_valid,
  input  logic [1:0]          coin_sel,
  input  logic                cancel,
  output logic                dispense,
  output logic                change_out,
  output logic                coin_reject,
  output logic                busy,
  output logic [CREDIT_W-1:0] credit,
  output logic [CNT_W-1:0]    vend_count
);

  // Parameter sanity. Any of these failing makes the change logic unable to
  // pay back exactly, or the credit register unable to hold MAX_CREDIT.
  if (PRICE % CHANGE_UNIT != 0 || COIN0 % CHANGE_UNIT != 0 ||
      COIN1 % CHANGE_UNIT != 0 || COIN2 % CHANGE_UNIT != 0 ||
      MAX_CREDIT % CHANGE_UNIT != 0) begin : g_bad_unit
    $error("vending_machine_ctrl: values must be multiples of CHANGE_UNIT");
  end
  if (PRICE > MAX_CREDIT) begin : g_bad_price
    $error("vending_machine_ctrl: PRICE exceeds MAX_CREDIT");
  end
  if (MAX_CREDIT >= 2**CREDIT_W) begin : g_bad_max
    $error("vending_machine_ctrl: MAX_CREDIT does not fit in CREDIT_W bits");
  end

  typedef enum logic [1:0] {
    S_ACCEPT = 2'd0,
    S_VEND   = 2'd1,
    S_CHANGE = 2'd2
  } state_t;

  // Sum-width constants for the overflow and threshold compares.
  localparam logic [CREDIT_W:0]   MAX_W   = (CREDIT_W+1)'(MAX_CREDIT);
  localparam logic [CREDIT_W:0]   PRICE_W = (CREDIT_W+1)'(PRICE);
  localparam logic [CREDIT_W:0]   COIN0_W = (CREDIT_W+1)'(COIN0);
  localparam logic [CREDIT_W:0]   COIN1_W = (CREDIT_W+1)'(COIN1);
  localparam logic [CREDIT_W:0]   COIN2_W = (CREDIT_W+1)'(COIN2);
  // Credit-width constants for the subtractions.
  localparam logic [CREDIT_W-1:0] PRICE_N = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W-1:0] UNIT_N  = CREDIT_W'(CHANGE_UNIT);

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [CNT_W-1:0]    vend_count_q, vend_count_d;
  logic                coin_reject_q, coin_reject_d;

  logic [CREDIT_W:0]   coin_val;
  logic                coin_ok;
  logic [CREDIT_W:0]   credit_sum;

  // Coin decode and the one-bit-wider sum used for the overflow check.
  always_comb begin
    coin_val = '0;
    coin_ok  = 1'b0;
    case (coin_sel)
      2'd0:    begin coin_val = COIN0_W; coin_ok = 1'b1; end
      2'd1:    begin coin_val = COIN1_W; coin_ok = 1'b1; end
      2'd2:    begin coin_val = COIN2_W; coin_ok = 1'b1; end
      default: begin coin_val = '0;      coin_ok = 1'b0; end
    endcase
    credit_sum = {1'b0, credit_q} + coin_val;
  end

  // Next-state logic.
  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    vend_count_d  = vend_count_q;
    coin_reject_d = 1'b0;
    case (state_q)
      S_ACCEPT: begin
        if (cancel && (credit_q != '0)) begin
          // Cancel wins over a coin arriving in the same cycle; the refund
          // covers only the credit already held.
          state_d       = S_CHANGE;
          coin_reject_d = coin_valid;
        end else if (coin_valid) begin
          if (coin_ok && (credit_sum <= MAX_W)) begin
            credit_d = credit_sum[CREDIT_W-1:0];
            if (credit_sum >= PRICE_W) begin
              state_d = S_VEND;
            end
          end else begin
            coin_reject_d = 1'b1;
          end
        end
      end
      S_VEND: begin
        coin_reject_d = coin_valid;
        vend_count_d  = vend_count_q + CNT_W'(1);
        credit_d      = (credit_q >= PRICE_N) ? (credit_q - PRICE_N) : '0;
        state_d       = (credit_d != '0) ? S_CHANGE : S_ACCEPT;
      end
      S_CHANGE: begin
        coin_reject_d = coin_valid;
        if (credit_q > UNIT_N) begin
          credit_d = credit_q - UNIT_N;
        end else begin
          // Last unit of change: saturate at zero and return to idle.
          credit_d = '0;
          state_d  = S_ACCEPT;
        end
      end
      default: begin
        state_d  = S_ACCEPT;
        credit_d = '0;
      end
    endcase
  end

  // ---- register stage ----
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= S_ACCEPT;
      credit_q      <= '0;
      vend_count_q  <= '0;
      coin_reject_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      vend_count_q  <= vend_count_d;
      coin_reject_q <= coin_reject_d;
    end
  end

  // Outputs are flops or a decode of the state flop only.
  assign dispense    = (state_q == S_VEND);
  assign change_out  = (state_q == S_CHANGE);
  assign busy        = (state_q != S_ACCEPT);
  assign coin_reject = coin_reject_q;
  assign credit      = credit_q;
  assign vend_count  = vend_count_q;

endmodule

// File: tb/tb_vending_machine_ctrl.sv
module tb_vending_machine_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;

  // Default-parameter instance.
  logic       coin_valid = 1'b0;
  logic [1:0] coin_sel   = 2'd0;
  logic       cancel     = 1'b0;
  logic       dispense, change_out, coin_reject, busy;
  logic [7:0] credit, vend_count;

  // Overflow instance: MAX_CREDIT=40, PRICE=40, COIN2=25.
  logic       coin_valid2 = 1'b0;
  logic [1:0] coin_sel2   = 2'd0;
  logic       cancel2     = 1'b0;
  logic       dispense2, change_out2, coin_reject2, busy2;
  logic [7:0] credit2, vend_count2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  vending_machine_ctrl dut (
    .CLK(CLK), .RST(RST), .coin_valid(coin_valid), .coin_sel(coin_sel),
    .cancel(cancel), .dispense(dispense), .change_out(change_out),
    .coin_reject(coin_reject), .busy(busy), .credit(credit),
    .vend_count(vend_count)
  );

  vending_machine_ctrl #(
    .PRICE(40), .MAX_CREDIT(40), .COIN2(25)
  ) dut2 (
    .CLK(CLK), .RST(RST), .coin_valid(coin_valid2), .coin_sel(coin_sel2),
    .cancel(cancel2), .dispense(dispense2), .change_out(change_out2),
    .coin_reject(coin_reject2), .busy(busy2), .credit(credit2),
    .vend_count(vend_count2)
  );

  // Advance one clock; sampling happens 1 time unit after the rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic put_coin(input logic [1:0] s);
    coin_valid = 1'b1;
    coin_sel   = s;
    tick();
    coin_valid = 1'b0;
  endtask

  task automatic put_coin2(input logic [1:0] s);
    coin_valid2 = 1'b1;
    coin_sel2   = s;
    tick();
    coin_valid2 = 1'b0;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (credit !== 8'd0) begin n_fail++; $display("FAIL reset_credit: got %0d want 0", credit); end
    n_checks++; if (vend_count !== 8'd0) begin n_fail++; $display("FAIL reset_vend_count: got %0d want 0", vend_count); end
    n_checks++; if ({dispense, change_out, coin_reject, busy} !== 4'b0000) begin n_fail++; $display("FAIL reset_outputs: got %b want 0000", {dispense, change_out, coin_reject, busy}); end
    n_checks++; if (credit2 !== 8'd0 || busy2 !== 1'b0) begin n_fail++; $display("FAIL reset_dut2: credit %0d busy %b want 0 0", credit2, busy2); end
  endtask

  task automatic test_three_tens();
    do_reset();
    put_coin(2'd1);
    n_checks++; if (credit !== 8'd10 || busy !== 1'b0) begin n_fail++; $display("FAIL tens_c10: credit %0d busy %b want 10 0", credit, busy); end
    put_coin(2'd1);
    n_checks++; if (credit !== 8'd20 || busy !== 1'b0) begin n_fail++; $display("FAIL tens_c20: credit %0d busy %b want 20 0", credit, busy); end
    put_coin(2'd1);
    n_checks++; if (credit !== 8'd30 || dispense !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL tens_vend: credit %0d disp %b busy %b want 30 1 1", credit, dispense, busy); end
    tick();
    n_checks++; if (dispense !== 1'b0 || change_out !== 1'b1 || credit !== 8'd5 || vend_count !== 8'd1) begin n_fail++; $display("FAIL tens_change: disp %b chg %b credit %0d vc %0d want 0 1 5 1", dispense, change_out, credit, vend_count); end
    tick();
    n_checks++; if (change_out !== 1'b0 || busy !== 1'b0 || credit !== 8'd0 || vend_count !== 8'd1) begin n_fail++; $display("FAIL tens_done: chg %b busy %b credit %0d vc %0d want 0 0 0 1", change_out, busy, credit, vend_count); end
  endtask

  task automatic test_single25_wrap();
    int chg_seen;
    do_reset();
    put_coin(2'd2);
    n_checks++; if (dispense !== 1'b1 || busy !== 1'b1 || change_out !== 1'b0) begin n_fail++; $display("FAIL s25_vend: disp %b busy %b chg %b want 1 1 0", dispense, busy, change_out); end
    tick();
    n_checks++; if (dispense !== 1'b0 || busy !== 1'b0 || change_out !== 1'b0 || credit !== 8'd0 || vend_count !== 8'd1) begin n_fail++; $display("FAIL s25_after: disp %b busy %b chg %b credit %0d vc %0d want 0 0 0 0 1", dispense, busy, change_out, credit, vend_count); end
    chg_seen = 0;
    for (int i = 1; i < 256; i++) begin
      put_coin(2'd2);
      if (change_out) chg_seen++;
      tick();
      if (change_out) chg_seen++;
    end
    n_checks++; if (vend_count !== 8'd0) begin n_fail++; $display("FAIL s25_wrap: vc %0d want 0", vend_count); end
    n_checks++; if (chg_seen != 0) begin n_fail++; $display("FAIL s25_no_change: change cycles %0d want 0", chg_seen); end
  endtask

  task automatic test_cancel();
    int n_chg, n_disp;
    do_reset();
    put_coin(2'd1);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    n_checks++; if (busy !== 1'b1 || credit !== 8'd10) begin n_fail++; $display("FAIL cancel_enter: busy %b credit %0d want 1 10", busy, credit); end
    n_chg = 0;
    n_disp = 0;
    for (int i = 0; i < 10; i++) begin
      if (change_out) n_chg++;
      if (dispense) n_disp++;
      tick();
    end
    n_checks++; if (n_chg != 2 || n_disp != 0) begin n_fail++; $display("FAIL cancel_refund: change %0d dispense %0d want 2 0", n_chg, n_disp); end
    n_checks++; if (credit !== 8'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL cancel_end: credit %0d busy %b want 0 0", credit, busy); end
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    n_checks++; if (busy !== 1'b0 || change_out !== 1'b0 || credit !== 8'd0) begin n_fail++; $display("FAIL cancel_zero: busy %b chg %b credit %0d want 0 0 0", busy, change_out, credit); end
  endtask

  task automatic test_reject();
    do_reset();
    // Coin during VEND.
    put_coin(2'd2);
    put_coin(2'd0);
    n_checks++; if (coin_reject !== 1'b1 || credit !== 8'd0 || vend_count !== 8'd1) begin n_fail++; $display("FAIL rej_vend: rej %b credit %0d vc %0d want 1 0 1", coin_reject, credit, vend_count); end
    tick();
    n_checks++; if (coin_reject !== 1'b0) begin n_fail++; $display("FAIL rej_vend_pulse: rej %b want 0", coin_reject); end
    // Coin during CHANGE.
    put_coin(2'd1);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    put_coin(2'd2);
    n_checks++; if (coin_reject !== 1'b1 || credit !== 8'd5 || change_out !== 1'b1) begin n_fail++; $display("FAIL rej_change: rej %b credit %0d chg %b want 1 5 1", coin_reject, credit, change_out); end
    tick();
    n_checks++; if (coin_reject !== 1'b0 || credit !== 8'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL rej_change_end: rej %b credit %0d busy %b want 0 0 0", coin_reject, credit, busy); end
    // Invalid coin in ACCEPT, back to back.
    put_coin(2'd3);
    n_checks++; if (coin_reject !== 1'b1 || credit !== 8'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL rej_sel3: rej %b credit %0d busy %b want 1 0 0", coin_reject, credit, busy); end
    put_coin(2'd3);
    n_checks++; if (coin_reject !== 1'b1) begin n_fail++; $display("FAIL rej_sel3_b2b: rej %b want 1", coin_reject); end
    tick();
    n_checks++; if (coin_reject !== 1'b0) begin n_fail++; $display("FAIL rej_sel3_end: rej %b want 0", coin_reject); end
    // Cancel and coin together: cancel wins, coin rejected.
    put_coin(2'd1);
    coin_valid = 1'b1;
    coin_sel   = 2'd0;
    cancel     = 1'b1;
    tick();
    coin_valid = 1'b0;
    cancel     = 1'b0;
    n_checks++; if (coin_reject !== 1'b1 || credit !== 8'd10 || change_out !== 1'b1) begin n_fail++; $display("FAIL rej_cancel_coin: rej %b credit %0d chg %b want 1 10 1", coin_reject, credit, change_out); end
    tick();
    tick();
    n_checks++; if (credit !== 8'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL rej_cancel_end: credit %0d busy %b want 0 0", credit, busy); end
  endtask

  task automatic test_overflow();
    do_reset();
    put_coin2(2'd1);
    put_coin2(2'd1);
    n_checks++; if (credit2 !== 8'd20) begin n_fail++; $display("FAIL ovf_pre: credit %0d want 20", credit2); end
    put_coin2(2'd2);
    n_checks++; if (coin_reject2 !== 1'b1 || credit2 !== 8'd20 || busy2 !== 1'b0) begin n_fail++; $display("FAIL ovf_reject: rej %b credit %0d busy %b want 1 20 0", coin_reject2, credit2, busy2); end
    put_coin2(2'd1);
    put_coin2(2'd1);
    n_checks++; if (coin_reject2 !== 1'b0 || credit2 !== 8'd40 || dispense2 !== 1'b1) begin n_fail++; $display("FAIL ovf_at_max: rej %b credit %0d disp %b want 0 40 1", coin_reject2, credit2, dispense2); end
    tick();
    n_checks++; if (credit2 !== 8'd0 || busy2 !== 1'b0 || vend_count2 !== 8'd1) begin n_fail++; $display("FAIL ovf_vend: credit %0d busy %b vc %0d want 0 0 1", credit2, busy2, vend_count2); end
  endtask

  task automatic test_reset_mid_change();
    do_reset();
    put_coin(2'd1);
    put_coin(2'd1);
    put_coin(2'd2);
    n_checks++; if (credit !== 8'd45 || dispense !== 1'b1) begin n_fail++; $display("FAIL rmc_vend: credit %0d disp %b want 45 1", credit, dispense); end
    tick();
    n_checks++; if (credit !== 8'd20 || change_out !== 1'b1 || vend_count !== 8'd1) begin n_fail++; $display("FAIL rmc_change: credit %0d chg %b vc %0d want 20 1 1", credit, change_out, vend_count); end
    tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    n_checks++; if (credit !== 8'd0 || change_out !== 1'b0 || busy !== 1'b0 || dispense !== 1'b0 || vend_count !== 8'd0) begin n_fail++; $display("FAIL rmc_reset: credit %0d chg %b busy %b disp %b vc %0d want 0 0 0 0 0", credit, change_out, busy, dispense, vend_count); end
    put_coin(2'd1);
    n_checks++; if (credit !== 8'd10 || busy !== 1'b0 || coin_reject !== 1'b0) begin n_fail++; $display("FAIL rmc_accept: credit %0d busy %b rej %b want 10 0 0", credit, busy, coin_reject); end
  endtask

  initial begin
    test_reset();
    test_three_tens();
    test_single25_wrap();
    test_cancel();
    test_reject();
    test_overflow();
    test_reset_mid_change();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
